// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the fetch PC, starts a program on START,
// retires one instruction per unstalled RUN cycle and reports completion.
module pc_sequencer #(
  parameter int unsigned PC_W    = 10,
  parameter int unsigned LAST_PC = (32'd1 << PC_W) - 32'd1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             START,
  input  logic [PC_W-1:0]  START_ADDR,
  input  logic             STALL,
  input  logic             BRANCH,
  input  logic [8:0]       BOFFSET,
  input  logic             BSIGN,
  input  logic             SOFT_RESET,
  input  logic             HALT,
  output logic [PC_W-1:0]  PC,
  output logic             FETCH_EN,
  output logic             DONE,
  output logic             ERR,
  output logic [CNT_W-1:0] INSTR_CNT
);

  // Offset is taken at PC_W+1 bits; one extra bit keeps the forward sum exact.
  localparam int unsigned OW = PC_W + 1;
  localparam int unsigned EW = PC_W + 2;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   restart_q, restart_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              fetch_q, done_q;

  logic [EW-1:0]     pc_ext;
  logic [EW-1:0]     off_ext;
  logic [EW-1:0]     target;
  logic              borrow;
  logic              out_of_range;
  logic [CNT_W-1:0]  cnt_inc;

  // Candidate next PC for branch / sequential retires and its range check.
  always_comb begin
    pc_ext  = EW'(pc_q);
    off_ext = EW'(OW'(BOFFSET));
    borrow  = 1'b0;
    target  = pc_ext + EW'(1);
    if (BRANCH) begin
      if (BSIGN) begin
        borrow = (off_ext > pc_ext);
        target = pc_ext - off_ext;
      end else begin
        target = pc_ext + off_ext;
      end
    end
    out_of_range = borrow || (target > EW'(LAST_PC));
    cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
  end

  // Next-state and datapath update for the IDLE/LOAD/RUN/DONE sequencer.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    restart_d = restart_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
          restart_d = START_ADDR;
          pc_d      = START_ADDR;
          cnt_d     = '0;
          err_d     = 1'b0;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: state_d = S_RUN;
      S_RUN: begin
        if (!STALL) begin
          cnt_d = cnt_inc;
          if (HALT) begin
            state_d = S_DONE;
          end else if (SOFT_RESET) begin
            pc_d = restart_q;
          end else if (out_of_range) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            pc_d = target[PC_W-1:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; FETCH_EN/DONE follow the registered state.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      restart_q <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      fetch_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      restart_q <= restart_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      fetch_q   <= (state_d == S_RUN);
      done_q    <= (state_d == S_DONE);
    end
  end

  assign PC        = pc_q;
  assign FETCH_EN  = fetch_q;
  assign DONE      = done_q;
  assign ERR       = err_q;
  assign INSTR_CNT = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer (PC_W=10, LAST_PC=0x0FF, CNT_W=4).
module tb_pc_sequencer;

  localparam int unsigned PC_W    = 10;
  localparam int unsigned LAST_PC = 32'h0FF;
  localparam int unsigned CNT_W   = 4;
  localparam int          CNT_MAX = 15;

  logic             CLK;
  logic             RESET_N;
  logic             START;
  logic [PC_W-1:0]  START_ADDR;
  logic             STALL;
  logic             BRANCH;
  logic [8:0]       BOFFSET;
  logic             BSIGN;
  logic             SOFT_RESET;
  logic             HALT;
  logic [PC_W-1:0]  PC;
  logic             FETCH_EN;
  logic             DONE;
  logic             ERR;
  logic [CNT_W-1:0] INSTR_CNT;

  pc_sequencer #(.PC_W(PC_W), .LAST_PC(LAST_PC), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .START_ADDR(START_ADDR),
    .STALL(STALL), .BRANCH(BRANCH), .BOFFSET(BOFFSET), .BSIGN(BSIGN),
    .SOFT_RESET(SOFT_RESET), .HALT(HALT), .PC(PC), .FETCH_EN(FETCH_EN),
    .DONE(DONE), .ERR(ERR), .INSTR_CNT(INSTR_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int pc;
    int fetch;
    int done;
    int err;
    int cnt;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: 0 idle, 1 load, 2 run, 3 done.
  int m_state, m_pc, m_cnt, m_err, m_restart;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_pc = 0; m_cnt = 0; m_err = 0; m_restart = 0;
  endtask

  task automatic model_step();
    int t;
    case (m_state)
      0, 3: if (START) begin
        m_restart = int'(START_ADDR);
        m_pc = m_restart; m_cnt = 0; m_err = 0; m_state = 1;
      end
      1: m_state = 2;
      default: if (!STALL) begin
        if (m_cnt < CNT_MAX) m_cnt++;
        if (HALT) m_state = 3;
        else if (SOFT_RESET) m_pc = m_restart;
        else begin
          if (BRANCH) t = BSIGN ? m_pc - int'(BOFFSET) : m_pc + int'(BOFFSET);
          else t = m_pc + 1;
          if (t < 0 || t > int'(LAST_PC)) begin m_state = 3; m_err = 1; end
          else m_pc = t;
        end
      end
    endcase
  endtask

  task automatic clr_in();
    START = 0; STALL = 0; BRANCH = 0; BOFFSET = '0; BSIGN = 0;
    SOFT_RESET = 0; HALT = 0;
  endtask

  // Push the model's prediction, clock once, pop and compare every output.
  task automatic step();
    exp_t e;
    model_step();
    e.pc = m_pc; e.fetch = (m_state == 2) ? 1 : 0; e.done = (m_state == 3) ? 1 : 0;
    e.err = m_err; e.cnt = m_cnt;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("pc", 32'(PC), 32'(e.pc));
      check("fetch_en", 32'(FETCH_EN), 32'(e.fetch));
      check("done", 32'(DONE), 32'(e.done));
      check("err", 32'(ERR), 32'(e.err));
      check("instr_cnt", 32'(INSTR_CNT), 32'(e.cnt));
    end
    @(negedge CLK);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pc"}, 32'(PC), 32'd0);
    check({tag, "_fetch"}, 32'(FETCH_EN), 32'd0);
    check({tag, "_done"}, 32'(DONE), 32'd0);
    check({tag, "_err"}, 32'(ERR), 32'd0);
    check({tag, "_cnt"}, 32'(INSTR_CNT), 32'd0);
  endtask

  task automatic start_prog(input logic [PC_W-1:0] addr);
    clr_in();
    START = 1; START_ADDR = addr;
    step();
    START = 0;
  endtask

  initial begin
    RESET_N = 0; START_ADDR = '0; clr_in(); model_reset();
    #2;
    check_all_zero("por");
    @(negedge CLK);
    RESET_N = 1;

    // Reset mid-run
    start_prog(10'd5);
    step();
    repeat (3) step();
    check("mid_pc", 32'(PC), 32'd8);
    #2;
    RESET_N = 0;
    model_reset();
    #1;
    check_all_zero("async_rst");
    @(posedge CLK); #1;
    check_all_zero("rst_held");
    @(negedge CLK);
    RESET_N = 1;

    // Linear run ending in HALT (HALT wins over SOFT_RESET)
    start_prog(10'h010);
    check("lin_load_fetch", 32'(FETCH_EN), 32'd0);
    check("lin_load_pc", 32'(PC), 32'h010);
    step();
    repeat (4) step();
    HALT = 1; SOFT_RESET = 1;
    step();
    clr_in();
    check("lin_done", 32'(DONE), 32'd1);
    check("lin_cnt", 32'(INSTR_CNT), 32'd5);
    check("lin_pc", 32'(PC), 32'h014);
    check("lin_err", 32'(ERR), 32'd0);

    // Restart from DONE, then stall and soft reset
    start_prog(10'h030);
    check("rs_done_low", 32'(DONE), 32'd0);
    check("rs_cnt", 32'(INSTR_CNT), 32'd0);
    check("rs_pc", 32'(PC), 32'h030);
    step();
    step();
    STALL = 1; BRANCH = 1; BOFFSET = 9'd9; HALT = 1;
    repeat (3) step();
    check("stall_pc", 32'(PC), 32'h031);
    check("stall_cnt", 32'(INSTR_CNT), 32'd1);
    clr_in();
    SOFT_RESET = 1;
    step();
    check("srst_pc", 32'(PC), 32'h030);
    check("srst_run", 32'(FETCH_EN), 32'd1);
    clr_in(); HALT = 1;
    step();

    // Branches from 0x020
    start_prog(10'h020);
    step();
    BRANCH = 1; BOFFSET = 9'd7; BSIGN = 0;
    step();
    check("br_fwd", 32'(PC), 32'h027);
    BOFFSET = 9'd3; BSIGN = 1;
    step();
    check("br_back", 32'(PC), 32'h024);
    BOFFSET = 9'd1; BSIGN = 0;
    step();
    check("br_one", 32'(PC), 32'h025);
    BOFFSET = 9'd0;
    step();
    check("br_zero", 32'(PC), 32'h025);
    clr_in(); HALT = 1;
    step();

    // Range errors: borrow and above LAST_PC
    start_prog(10'h002);
    step();
    BRANCH = 1; BOFFSET = 9'd5; BSIGN = 1;
    step();
    clr_in();
    check("borrow_done", 32'(DONE), 32'd1);
    check("borrow_err", 32'(ERR), 32'd1);
    check("borrow_pc", 32'(PC), 32'h002);
    start_prog(10'h0FF);
    check("over_err_clr", 32'(ERR), 32'd0);
    step();
    step();
    check("over_done", 32'(DONE), 32'd1);
    check("over_err", 32'(ERR), 32'd1);
    check("over_pc", 32'(PC), 32'h0FF);

    // Saturation, with a START in RUN that must be ignored
    start_prog(10'h000);
    step();
    for (int i = 0; i < 20; i++) begin
      START = (i == 5); START_ADDR = 10'h080;
      step();
    end
    START = 0;
    check("sat_cnt", 32'(INSTR_CNT), 32'd15);
    check("sat_pc", 32'(PC), 32'd20);

    // Random mixed traffic
    for (int i = 0; i < 80; i++) begin
      START      = ($urandom_range(0, 2) == 0);
      START_ADDR = PC_W'($urandom_range(0, 255));
      STALL      = ($urandom_range(0, 3) == 0);
      BRANCH     = ($urandom_range(0, 2) == 0);
      BOFFSET    = 9'($urandom_range(0, 40));
      BSIGN      = ($urandom_range(0, 1) == 1);
      SOFT_RESET = ($urandom_range(0, 9) == 0);
      HALT       = ($urandom_range(0, 11) == 0);
      step();
    end
    clr_in();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer that drives instruction fetch for the ALU-based core. It owns the PC, starts a program on a START pulse and retires one instruction per unstalled cycle. Each next PC comes from the ALU's branch outputs (BOFFSET/BSIGN) or its soft-reset/halt outputs. It sits between instruction memory (PC out) and the ALU/decoder (control in), and reports completion to the top-level test harness.

## Interface
- PC_W, default 10: PC width in bits; instruction memory depth is 2^PC_W.
- LAST_PC, default 2^PC_W-1: highest legal PC; a next PC above it ends the run with ERR.
- CNT_W, default 16: width of the retired-instruction counter.

- CLK  in  1  clock; all state updates on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- START  in  1  request to begin a program; sampled in IDLE or DONE only.
- START_ADDR  in  PC_W  first PC of the program; latched when START is accepted.
- STALL  in  1  hold: no retire and no PC change this cycle.
- BRANCH  in  1  decoder flag: the current instruction is kBRC, kBRR or kBRO.
- BOFFSET  in  9  ALU branch offset (unsigned magnitude).
- BSIGN  in  1  ALU branch direction: 1 = backward, 0 = forward.
- SOFT_RESET  in  1  ALU reset output (kRST).
- HALT  in  1  ALU halt output (kRST with toggle bit set).
- PC  out  PC_W  current fetch address.
- FETCH_EN  out  1  high when the instruction at PC is executing this cycle.
- DONE  out  1  level; high while in the DONE state.
- ERR  out  1  level; high when the run ended on a PC range violation.
- INSTR_CNT  out  CNT_W  count of retired instructions in the current run; saturates at all-ones.

## Operation
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - START=1 -> latch START_ADDR into the restart register; PC <= START_ADDR.
  - Clear INSTR_CNT and ERR; go to LOAD.
- LOAD: one bubble cycle so memory sees the new PC. FETCH_EN=0. Go to RUN unconditionally.
- RUN: FETCH_EN=1. A retire happens on any RUN cycle with STALL=0. On a retire, apply the first matching rule:
  1. HALT=1 -> go to DONE; PC unchanged; the instruction counts as retired.
  2. SOFT_RESET=1 -> PC <= latched START_ADDR; stay in RUN.
  3. BRANCH=1 -> PC <= BSIGN ? PC - BOFFSET : PC + BOFFSET.
  4. Otherwise -> PC <= PC + 1.
- Arithmetic for rules 3-4:
  - Compute at PC_W+1 bits, with BOFFSET zero-extended or truncated to PC_W+1.
  - Result below 0 (borrow) or above LAST_PC -> go to DONE with ERR=1; PC unchanged.
  - Otherwise PC takes the result.
- BRANCH with BOFFSET=0 is legal: PC holds and the same instruction re-executes. No watchdog.
- On every retire, INSTR_CNT increments, saturating at 2^CNT_W-1.
- STALL=1 in RUN: PC, state and INSTR_CNT all hold. BRANCH, BOFFSET, BSIGN, SOFT_RESET and HALT are ignored that cycle.
- DONE:
  - FETCH_EN=0; DONE=1; PC, ERR and INSTR_CNT hold.
  - START=1 -> behaves as in IDLE, and DONE drops on the next edge.
- START in LOAD or RUN is ignored.
- RESET_N low, at any time including mid-run:
  - State goes to IDLE immediately.
  - PC=0, FETCH_EN=0, DONE=0, ERR=0, INSTR_CNT=0, restart register=0.

## Timing
- Reset values: all outputs 0, state IDLE.
- START sampled high at edge N -> PC=START_ADDR after edge N. FETCH_EN is 0 during cycle N+1 (LOAD) and goes high after edge N+1.
- Next PC is registered: ALU/decoder inputs sampled at edge K determine PC after edge K. No combinational path from inputs to PC.
- FETCH_EN, DONE and ERR are decoded from registered state only (Moore outputs).
- HALT retiring at edge K -> DONE=1 and FETCH_EN=0 after edge K.
- A run of M unstalled instructions ending in a halt takes M+1 cycles from START acceptance to DONE.

## Test plan
- Reset mid-run:
  - Stimulus: START_ADDR=5, START, 3 plain retires, then RESET_N low.
  - Required: PC=0 and state IDLE immediately (asynchronously); all outputs 0 while reset is held.
- Linear run with halt:
  - Stimulus: START_ADDR=0x010, 4 plain cycles, then HALT=1, SOFT_RESET=1.
  - Required: PC steps 0x010..0x014; DONE=1 after the halt edge; INSTR_CNT=5; ERR=0.
- Branches at PC=0x020:
  - BRANCH=1, BOFFSET=7, BSIGN=0 -> PC=0x027.
  - Then BRANCH=1, BOFFSET=3, BSIGN=1 -> PC=0x024.
  - Then BRANCH=1, BOFFSET=1 (not-taken form) -> PC=0x025.
- Range errors:
  - PC=0x002, BRANCH=1, BOFFSET=5, BSIGN=1 -> DONE=1, ERR=1, PC stays 0x002.
  - With LAST_PC=0x0FF: PC=0x0FF plain retire -> DONE=1, ERR=1.
- Stall and soft reset:
  - Stimulus: STALL=1 for 3 cycles with BRANCH=1 asserted.
  - Required: PC and INSTR_CNT unchanged throughout.
  - Then SOFT_RESET=1, HALT=0 -> PC=START_ADDR, state stays RUN.
- Restart from DONE, plus saturation:
  - Stimulus: START with START_ADDR=0x030 while in DONE.
  - Required: DONE low after the edge; LOAD cycle; INSTR_CNT=0; PC=0x030.
  - Saturation (CNT_W=4): 20 retires -> INSTR_CNT=15.
